rv32i_writeback: RTL and testbench
==================================

// Module: rv32i_writeback
// PURPOSE
//  Stage-5 writeback: final writer into the 31-entry base register file (x0 hardwired to zero).
//  - Takes results from memory stage; aligns/sign-extends load data; waits for memory read ack.
//  - Drives the register-file write port from registered outputs.
//  - Stalls the pipeline while a load is outstanding; aborts it on flush or ack timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in WAIT_ACK before abort; legal range 1..255; counter is 8 bits
// PORTS
//  i_clk         in   1   clock, all state on rising edge
//  i_rst         in   1   asynchronous, active-high reset
//  i_ce          in   1   stage-5 enable: valid instruction presented this cycle
//  i_flush       in   1   discard in-flight instruction (branch/trap)
//  i_wr_rd       in   1   instruction writes rd
//  i_rd_addr     in   5   destination register index
//  i_rd_alu      in   32  non-load result (ALU/JAL link/LUI/AUIPC)
//  i_is_load     in   1   instruction is a load
//  i_funct3      in   3   load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  i_addr_lsb    in   2   byte offset of load address
//  i_ack         in   1   memory read data valid
//  i_rdata       in   32  memory read word
//  o_rd_addr     out  5   register-file write address
//  o_rd          out  32  register-file write data
//  o_wr          out  1   register-file write enable, one-cycle pulse
//  o_stall       out  1   hold stages 1-4
//  o_bus_err     out  1   one-cycle pulse on load timeout
// BEHAVIOUR
//  - Reset: o_rd_addr=0, o_rd=0, o_wr=0, o_bus_err=0, state=IDLE, timeout counter=0.
//  - o_stall is combinational: 1 iff state=WAIT_ACK. It is 0 during reset.
//  - o_wr is forced to 0 whenever o_rd_addr==0.
//  - Non-load in IDLE (i_ce=1, i_is_load=0, no flush): next edge o_wr=i_wr_rd, o_rd=i_rd_alu, o_rd_addr=i_rd_addr.
//  - Load in IDLE with i_ack=1 in the same cycle: written next edge with aligned data (latency 1, no stall).
//  - Load in IDLE with i_ack=0: capture rd_addr, funct3, addr_lsb and i_wr_rd; go to WAIT_ACK; counter=0.
//  - WAIT_ACK, i_ack=1: next edge write aligned i_rdata; return to IDLE. i_ce is ignored in WAIT_ACK.
//  - WAIT_ACK, no ack: counter increments each cycle. When counter==TIMEOUT_CYCLES-1 with no ack:
//    pulse o_bus_err, no write, return to IDLE.
//  - i_flush has priority over everything, in either state: no write, state=IDLE, counter cleared.
//    A late ack after flush or timeout is ignored.
//  - Simultaneous ack and timeout expiry: ack wins (write, no error).
//  - Alignment:
//    - LB/LBU: byte = i_rdata[8*lsb+:8].
//    - LH/LHU: half = i_rdata[16*lsb[1]+:16]; lsb[0] is ignored, misalignment is trapped upstream.
//    - LW: full word.
//    - LB/LH sign-extend; LBU/LHU zero-extend.
//    - Undefined funct3 (011, 11x) treated as LW.
//  - o_wr is never asserted for more than one cycle per instruction.
//  - Async reset asserted in WAIT_ACK aborts the load without a write.
// CONFIGURATION
//  RV32I_WB_BYPASS_EN defined:
//  - adds outputs o_fwd_valid(1), o_fwd_addr(5), o_fwd_data(32), combinationally equal to o_wr/o_rd_addr/o_rd.
//  - Decode uses them to forward around the register file's same-cycle read/write hazard.
//  Macro undefined: these ports do not exist; no other behaviour changes.
// STRUCTURE
//  - Shared header rv32i_header.vh holds the FUNCT3_LB/LH/LW/LBU/LHU localparams and the state encodings
//    WB_IDLE=1'b0, WB_WAIT_ACK=1'b1.
//  - One sub-module, rv32i_load_align: combinational (rdata, funct3, addr_lsb) -> 32-bit aligned/extended word.
//  - FSM, capture registers and timeout counter live in the top level.
// TESTING
//  1. ALU write: i_ce=1, i_wr_rd=1, rd=5, alu=0xDEADBEEF -> next edge o_wr=1, o_rd_addr=5, o_rd=0xDEADBEEF; o_wr=0 after.
//  2. x0 suppression: rd=0, i_wr_rd=1, alu=0x1234 -> o_wr stays 0.
//  3. Load align:
//     - LB, lsb=3, rdata=0x80FF0011 -> o_rd=0xFFFFFF80.
//     - LHU, lsb=2, same rdata -> o_rd=0x000080FF.
//     - LW -> 0x80FF0011.
//  4. Delayed ack: LH rd=7, ack after 3 cycles, rdata=0x0000F00D, lsb=0 -> o_stall=1 for exactly 3 cycles,
//     then o_wr=1, o_rd=0xFFFFF00D.
//  5. Timeout, TIMEOUT_CYCLES=4, no ack -> o_stall high 4 cycles, o_bus_err pulses once, no o_wr;
//     a later ack causes no write.
//  6. Flush in WAIT_ACK on cycle 2 -> o_stall drops next cycle, no write.
//     Same-cycle ack plus flush -> no write.
//     Async reset mid-wait -> all outputs 0 immediately.

Source files
------------

// File: rtl/rv32i_writeback_pkg.sv
// Shared types and constants for the rv32i writeback stage and its load aligner.
package rv32i_writeback_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned LSB_W  = 2;
  localparam int unsigned CNT_W  = 8;

  localparam logic [F3_W-1:0] FUNCT3_LB  = 3'b000;
  localparam logic [F3_W-1:0] FUNCT3_LH  = 3'b001;
  localparam logic [F3_W-1:0] FUNCT3_LW  = 3'b010;
  localparam logic [F3_W-1:0] FUNCT3_LBU = 3'b100;
  localparam logic [F3_W-1:0] FUNCT3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_ACK = 1'b1
  } wb_state_e;

  // Load context held while the memory read is outstanding
  typedef struct packed {
    logic [REG_AW-1:0] rd_addr;
    logic [F3_W-1:0]   funct3;
    logic [LSB_W-1:0]  addr_lsb;
    logic              wr_rd;
  } wb_load_ctx_t;

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
    return {{(XLEN-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
    return {{(XLEN-16){sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational load-data aligner: selects byte/half/word from the read word and extends it.
module rv32i_load_align
  import rv32i_writeback_pkg::*;
(
  input  logic [XLEN-1:0]  i_rdata,
  input  logic [F3_W-1:0]  i_funct3,
  input  logic [LSB_W-1:0] i_addr_lsb,
  output logic [XLEN-1:0]  o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lsb)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    // Halfword misalignment is trapped upstream, so only lsb[1] matters
    w_half = i_addr_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      FUNCT3_LB:  o_data = ext8(w_byte, 1'b1);
      FUNCT3_LH:  o_data = ext16(w_half, 1'b1);
      FUNCT3_LBU: o_data = ext8(w_byte, 1'b0);
      FUNCT3_LHU: o_data = ext16(w_half, 1'b0);
      default:    o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_writeback.sv
// Stage-5 writeback: register-file write port, load-ack wait with timeout, pipeline stall.
// Optional RV32I_WB_BYPASS_EN adds o_fwd_* ports mirroring the write port for decode forwarding.
module rv32i_writeback
  import rv32i_writeback_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic              i_flush,
  input  logic              i_wr_rd,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  logic [XLEN-1:0]   i_rd_alu,
  input  logic              i_is_load,
  input  logic [F3_W-1:0]   i_funct3,
  input  logic [LSB_W-1:0]  i_addr_lsb,
  input  logic              i_ack,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic [XLEN-1:0]   o_rd,
  output logic              o_wr,
  output logic              o_stall,
  output logic              o_bus_err
`ifdef RV32I_WB_BYPASS_EN
  ,
  output logic              o_fwd_valid,
  output logic [REG_AW-1:0] o_fwd_addr,
  output logic [XLEN-1:0]   o_fwd_data
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  wb_state_e         r_state, w_state_nxt;
  wb_load_ctx_t      r_ctx, w_ctx_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [REG_AW-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [XLEN-1:0]   r_rd, w_rd_nxt;
  logic              r_wr, w_wr_nxt;
  logic              r_bus_err, w_bus_err_nxt;

  logic [F3_W-1:0]   w_al_funct3;
  logic [LSB_W-1:0]  w_al_lsb;
  logic [XLEN-1:0]   w_aligned;

  // Aligner sees the live request in IDLE and the captured context while waiting
  assign w_al_funct3 = (r_state == WB_WAIT_ACK) ? r_ctx.funct3   : i_funct3;
  assign w_al_lsb    = (r_state == WB_WAIT_ACK) ? r_ctx.addr_lsb : i_addr_lsb;

  rv32i_load_align u_load_align (
    .i_rdata    (i_rdata),
    .i_funct3   (w_al_funct3),
    .i_addr_lsb (w_al_lsb),
    .o_data     (w_aligned)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= WB_IDLE;
      r_ctx     <= '0;
      r_cnt     <= '0;
      r_rd_addr <= '0;
      r_rd      <= '0;
      r_wr      <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ctx     <= w_ctx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_rd      <= w_rd_nxt;
      r_wr      <= w_wr_nxt;
      r_bus_err <= w_bus_err_nxt;
    end
  end

  // Flush dominates; ack dominates timeout; writes to x0 never assert the enable
  always_comb begin
    w_state_nxt   = r_state;
    w_ctx_nxt     = r_ctx;
    w_cnt_nxt     = r_cnt;
    w_rd_addr_nxt = r_rd_addr;
    w_rd_nxt      = r_rd;
    w_wr_nxt      = 1'b0;
    w_bus_err_nxt = 1'b0;

    if (i_flush) begin
      w_state_nxt = WB_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (i_ce) begin
            if (!i_is_load) begin
              w_rd_addr_nxt = i_rd_addr;
              w_rd_nxt      = i_rd_alu;
              w_wr_nxt      = i_wr_rd && (i_rd_addr != '0);
            end else if (i_ack) begin
              w_rd_addr_nxt = i_rd_addr;
              w_rd_nxt      = w_aligned;
              w_wr_nxt      = i_wr_rd && (i_rd_addr != '0);
            end else begin
              w_ctx_nxt   = '{rd_addr: i_rd_addr, funct3: i_funct3,
                              addr_lsb: i_addr_lsb, wr_rd: i_wr_rd};
              w_cnt_nxt   = '0;
              w_state_nxt = WB_WAIT_ACK;
            end
          end
        end
        WB_WAIT_ACK: begin
          if (i_ack) begin
            w_rd_addr_nxt = r_ctx.rd_addr;
            w_rd_nxt      = w_aligned;
            w_wr_nxt      = r_ctx.wr_rd && (r_ctx.rd_addr != '0);
            w_cnt_nxt     = '0;
            w_state_nxt   = WB_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            w_bus_err_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = WB_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = WB_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_rd_addr = r_rd_addr;
  assign o_rd      = r_rd;
  assign o_wr      = r_wr;
  assign o_bus_err = r_bus_err;
  assign o_stall   = (r_state == WB_WAIT_ACK);

`ifdef RV32I_WB_BYPASS_EN
  assign o_fwd_valid = r_wr;
  assign o_fwd_addr  = r_rd_addr;
  assign o_fwd_data  = r_rd;
`endif

endmodule

// File: tb/tb_rv32i_writeback.sv
// Scoreboard bench for rv32i_writeback (TIMEOUT_CYCLES=4): directed ALU/load/timeout/flush/reset vectors.
module tb_rv32i_writeback;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ce, i_flush, i_wr_rd, i_is_load, i_ack;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_rd_alu, i_rdata;
  logic [2:0]  i_funct3;
  logic [1:0]  i_addr_lsb;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd;
  logic        o_wr, o_stall, o_bus_err;
`ifdef RV32I_WB_BYPASS_EN
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_addr;
  logic [31:0] o_fwd_data;
`endif

  wr_t exp_wr_q[$];
  int  exp_err;
  int  tests;
  int  fails;
  int  stall_cycles;

  always #5 clk = ~clk;

  rv32i_writeback #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ce       (i_ce),
    .i_flush    (i_flush),
    .i_wr_rd    (i_wr_rd),
    .i_rd_addr  (i_rd_addr),
    .i_rd_alu   (i_rd_alu),
    .i_is_load  (i_is_load),
    .i_funct3   (i_funct3),
    .i_addr_lsb (i_addr_lsb),
    .i_ack      (i_ack),
    .i_rdata    (i_rdata),
    .o_rd_addr  (o_rd_addr),
    .o_rd       (o_rd),
    .o_wr       (o_wr),
    .o_stall    (o_stall),
    .o_bus_err  (o_bus_err)
`ifdef RV32I_WB_BYPASS_EN
    ,
    .o_fwd_valid(o_fwd_valid),
    .o_fwd_addr (o_fwd_addr),
    .o_fwd_data (o_fwd_data)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    i_ce = 1'b0; i_flush = 1'b0; i_wr_rd = 1'b0; i_is_load = 1'b0; i_ack = 1'b0;
    i_rd_addr = '0; i_rd_alu = '0; i_rdata = '0; i_funct3 = '0; i_addr_lsb = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic wr, input logic [31:0] d);
    i_ce = 1'b1; i_wr_rd = wr; i_rd_addr = rd; i_rd_alu = d; i_is_load = 1'b0;
    step();
    clear_in();
  endtask

  task automatic load_op(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lsb,
                         input logic ack, input logic [31:0] rdata);
    i_ce = 1'b1; i_wr_rd = 1'b1; i_rd_addr = rd; i_is_load = 1'b1;
    i_funct3 = f3; i_addr_lsb = lsb; i_ack = ack; i_rdata = rdata;
    step();
    clear_in();
  endtask

  // Monitor: pops expected writes / bus errors whenever the DUT presents them
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_stall) stall_cycles++;
        if (o_wr) begin
          if (exp_wr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write",
                     o_rd_addr, o_rd);
          end else begin
            e = exp_wr_q.pop_front();
            chk("wr_addr", 32'(o_rd_addr), 32'(e.addr));
            chk("wr_data", o_rd, e.data);
          end
        end
        if (o_bus_err) begin
          tests++;
          if (exp_err == 0) begin
            fails++;
            $display("FAIL unexpected_bus_err: got pulse expected none");
          end else begin
            exp_err--;
          end
        end
      end
    end
  endtask

  logic [2:0]  ld_f3  [8] = '{3'b000, 3'b101, 3'b010, 3'b001, 3'b100, 3'b001, 3'b100, 3'b011};
  logic [1:0]  ld_lsb [8] = '{2'd3, 2'd2, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1};
  logic [31:0] ld_exp [8] = '{32'hFFFFFF80, 32'h000080FF, 32'h80FF0011, 32'hFFFF80FF,
                              32'h000000FF, 32'h00000011, 32'h00000000, 32'h80FF0011};

  initial begin
    tests = 0; fails = 0; exp_err = 0; stall_cycles = 0;
    rst = 1'b1;
    clear_in();
    fork
      monitor();
    join_none
    step();
    step();
    chk("rst_wr", 32'(o_wr), 32'd0);
    chk("rst_rd", o_rd, 32'd0);
    chk("rst_addr", 32'(o_rd_addr), 32'd0);
    chk("rst_bus_err", 32'(o_bus_err), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    rst = 1'b0;

    // ALU write and single-cycle pulse
    exp_wr_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    alu_op(5'd5, 1'b1, 32'hDEADBEEF);
    chk("t1_wr_now", 32'(o_wr), 32'd1);
    step();
    chk("t1_wr_pulse", 32'(o_wr), 32'd0);

    // x0 suppression and wr_rd=0
    alu_op(5'd0, 1'b1, 32'h00001234);
    chk("t2_x0_wr", 32'(o_wr), 32'd0);
    alu_op(5'd6, 1'b0, 32'h00005678);
    chk("t2_nowr", 32'(o_wr), 32'd0);

    // Same-cycle-ack loads through every alignment case
    stall_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      exp_wr_q.push_back('{addr: 5'(10 + k), data: ld_exp[k]});
      load_op(5'(10 + k), ld_f3[k], ld_lsb[k], 1'b1, 32'h80FF0011);
    end
    step();
    chk("t3_no_stall", 32'(stall_cycles), 32'd0);

    // Delayed ack after 3 stall cycles; ce ignored while waiting
    exp_wr_q.push_back('{addr: 5'd7, data: 32'hFFFFF00D});
    stall_cycles = 0;
    load_op(5'd7, 3'b001, 2'd0, 1'b0, 32'h0);
    chk("t4_stall_on", 32'(o_stall), 32'd1);
    i_ce = 1'b1; i_wr_rd = 1'b1; i_rd_addr = 5'd9; i_rd_alu = 32'h0000AAAA;
    step();
    step();
    i_ack = 1'b1; i_rdata = 32'h0000F00D;
    step();
    clear_in();
    chk("t4_wr", 32'(o_wr), 32'd1);
    chk("t4_stall_off", 32'(o_stall), 32'd0);
    step();
    chk("t4_stall_cycles", 32'(stall_cycles), 32'd3);

    // Timeout after 4 cycles, late ack ignored
    stall_cycles = 0;
    exp_err++;
    load_op(5'd3, 3'b010, 2'd0, 1'b0, 32'h0);
    repeat (TO) step();
    chk("t5_bus_err", 32'(o_bus_err), 32'd1);
    chk("t5_no_wr", 32'(o_wr), 32'd0);
    chk("t5_stall_off", 32'(o_stall), 32'd0);
    step();
    chk("t5_err_pulse", 32'(o_bus_err), 32'd0);
    i_ack = 1'b1; i_rdata = 32'h12345678;
    step();
    clear_in();
    chk("t5_late_ack", 32'(o_wr), 32'd0);
    chk("t5_stall_cycles", 32'(stall_cycles), 32'd4);

    // Flush on second wait cycle
    stall_cycles = 0;
    load_op(5'd4, 3'b010, 2'd0, 1'b0, 32'h0);
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("t6_flush_stall", 32'(o_stall), 32'd0);
    chk("t6_flush_wr", 32'(o_wr), 32'd0);
    i_ack = 1'b1; i_rdata = 32'h11111111;
    step();
    clear_in();
    chk("t6_flush_late", 32'(o_wr), 32'd0);
    chk("t6_stall_cycles", 32'(stall_cycles), 32'd2);

    // Flush with ack, in WAIT_ACK and in IDLE
    load_op(5'd4, 3'b010, 2'd0, 1'b0, 32'h0);
    i_ack = 1'b1; i_flush = 1'b1; i_rdata = 32'h22222222;
    step();
    clear_in();
    chk("t6_ackflush_wait", 32'(o_wr), 32'd0);
    chk("t6_ackflush_stall", 32'(o_stall), 32'd0);
    i_flush = 1'b1;
    load_op(5'd8, 3'b010, 2'd0, 1'b1, 32'h33333333);
    chk("t6_ackflush_idle", 32'(o_wr), 32'd0);

    // Async reset mid-wait
    exp_wr_q.push_back('{addr: 5'd12, data: 32'h5A5A5A5A});
    alu_op(5'd12, 1'b1, 32'h5A5A5A5A);
    load_op(5'd13, 3'b010, 2'd0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", 32'(o_stall), 32'd0);
    chk("t6_rst_rd", o_rd, 32'd0);
    chk("t6_rst_addr", 32'(o_rd_addr), 32'd0);
    chk("t6_rst_wr", 32'(o_wr), 32'd0);
    step();
    rst = 1'b0;
    i_ack = 1'b1; i_rdata = 32'h44444444;
    step();
    clear_in();
    chk("t6_rst_late", 32'(o_wr), 32'd0);

    // Normal write after recovery
    exp_wr_q.push_back('{addr: 5'd31, data: 32'h0F0F0F0F});
    alu_op(5'd31, 1'b1, 32'h0F0F0F0F);
    step();
    step();

    chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    chk("err_queue_drained", 32'(exp_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
